// File: rtl/addmul_acc_pipe.sv
// Three-stage clock-enabled (a+b)*c pipeline.
// Optional batch accumulation with saturation and a sticky overflow flag.
module addmul_acc_pipe #(
    parameter int W      = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             mode,
    input  logic [CNT_W-1:0] acc_len,
    output logic [W:0]       sum_res,
    output logic [ACC_W-1:0] y,
    output logic             out_valid,
    output logic             ovf
);
    localparam int PW = 2*W + 1;
    localparam logic [ACC_W-1:0] SAT_HI = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] SAT_LO = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [W-1:0]     c_r;
    logic             mode1_r, v1_r, mode2_r, v2_r;
    logic [PW-1:0]    prod_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r, len_r;

    logic [W:0]       sum_s;
    logic [PW-1:0]    prod_s;
    logic [ACC_W-1:0] prod_ext_s, total_s;
    logic             sat_s, last_s;
    logic [CNT_W-1:0] eff_len_s;

    function automatic logic [W:0] ext_op(input logic [W-1:0] v);
        if (SIGNED != 0) ext_op = {v[W-1], v};
        else             ext_op = {1'b0, v};
    endfunction

    function automatic logic [PW-1:0] ext_sum(input logic [W:0] v);
        if (SIGNED != 0) ext_sum = {{(PW-W-1){v[W]}}, v};
        else             ext_sum = {{(PW-W-1){1'b0}}, v};
    endfunction

    function automatic logic [PW-1:0] ext_mul(input logic [W-1:0] v);
        if (SIGNED != 0) ext_mul = {{(PW-W){v[W-1]}}, v};
        else             ext_mul = {{(PW-W){1'b0}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] ext_prod(input logic [PW-1:0] v);
        if (SIGNED != 0) ext_prod = ACC_W'($signed(v));
        else             ext_prod = ACC_W'(v);
    endfunction

    // Returns {saturated, clamped sum}; one guard bit detects range overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] p);
        logic [ACC_W:0] wide;
        if (SIGNED != 0) begin
            wide = {x[ACC_W-1], x} + {p[ACC_W-1], p};
            if (wide[ACC_W] != wide[ACC_W-1]) sat_add = {1'b1, (wide[ACC_W] ? SAT_LO : SAT_HI)};
            else                              sat_add = {1'b0, wide[ACC_W-1:0]};
        end else begin
            wide = {1'b0, x} + {1'b0, p};
            if (wide[ACC_W]) sat_add = {1'b1, SAT_HI};
            else             sat_add = {1'b0, wide[ACC_W-1:0]};
        end
    endfunction

    // Datapath arithmetic and batch-boundary decode.
    always_comb begin
        sum_s               = ext_op(a) + ext_op(b);
        prod_s              = ext_sum(sum_res) * ext_mul(c_r);
        prod_ext_s          = ext_prod(prod_r);
        {sat_s, total_s}    = sat_add(acc_r, prod_ext_s);
        eff_len_s           = len_r;
        if (cnt_r == {CNT_W{1'b0}}) begin
            if (acc_len == {CNT_W{1'b0}}) eff_len_s = ONE;
            else                          eff_len_s = acc_len;
        end else begin
            eff_len_s = len_r;
        end
        last_s = (cnt_r == (eff_len_s - ONE));
    end

    // Stages 1 and 2: sum, then product, each with its valid and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_res <= {(W+1){1'b0}};
            c_r     <= {W{1'b0}};
            mode1_r <= 1'b0;
            v1_r    <= 1'b0;
            prod_r  <= {PW{1'b0}};
            mode2_r <= 1'b0;
            v2_r    <= 1'b0;
        end else if (ce) begin
            sum_res <= sum_s;
            c_r     <= c;
            mode1_r <= mode;
            v1_r    <= in_valid;
            prod_r  <= prod_s;
            mode2_r <= mode1_r;
            v2_r    <= v1_r;
        end
    end

    // Stage 3: output and accumulate; clr overrides batch state even when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= {ACC_W{1'b0}};
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            len_r     <= {CNT_W{1'b0}};
        end else begin
            if (ce) begin
                if (v2_r && !mode2_r) begin
                    y         <= prod_ext_s;
                    out_valid <= 1'b1;
                end else if (v2_r && !clr) begin
                    if (cnt_r == {CNT_W{1'b0}}) len_r <= eff_len_s;
                    if (sat_s) ovf <= 1'b1;
                    if (last_s) begin
                        y         <= total_s;
                        out_valid <= 1'b1;
                        acc_r     <= {ACC_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        acc_r     <= total_s;
                        cnt_r     <= cnt_r + ONE;
                        out_valid <= 1'b0;
                    end
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (clr) begin
                acc_r <= {ACC_W{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
                ovf   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/addmul_acc_pipe.md
Name: addmul_acc_pipe

Overview:
- Parametrised successor of the add-then-multiply summator datapath. Computes (a+b)*c in a 3-stage clock-enabled pipeline.
- Carries a valid flag through every stage.
- Adds a runtime-selectable accumulate mode: sums acc_len consecutive products with saturation and a sticky overflow flag.
- Sits between sample sources and the control-law arithmetic; replaces fixed-width vendor-IP chains.

Parameters:
W, 8, operand width of a, b, c
ACC_W, 24, accumulator/output width; must be >= 2W+1
CNT_W, 8, width of acc_len and the internal batch counter
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; 0 freezes every pipeline register, including valids
clr  in  1  synchronous clear of accumulator, counter and ovf; acts regardless of ce
in_valid  in  1  a/b/c/mode qualify this cycle
a  in  W  addend
b  in  W  addend
c  in  W  multiplier
mode  in  1  0 = pass-through product, 1 = accumulate
acc_len  in  CNT_W  batch length for mode 1
sum_res  out  W+1  stage-1 sum register
y  out  ACC_W  result
out_valid  out  1  y valid, one-cycle pulse per result
ovf  out  1  sticky saturation flag

Behaviour:
- Reset: rst_n low asynchronously clears to 0 every pipeline register, valid, sum_res, y, out_valid, ovf, the accumulator and the counter. Reset mid-batch discards the batch. Operation resumes on the first clk edge after rst_n rises.
- Pipeline, advancing only on edges where ce=1:
  - S1: sum_res <= a+b, extended to W+1 bits (zero-extended if SIGNED=0, sign-extended if SIGNED=1). Also registers c, mode and v1 <= in_valid.
  - S2: prod <= sum_res*c_s1, 2W+1 bits, signedness per SIGNED. Also registers mode and v2 <= v1.
  - S3: output and accumulate stage.
- S3, mode 0 sample (v2=1):
  - y <= prod extended to ACC_W; out_valid <= 1.
  - Accumulator and counter untouched, so an open mode-1 batch continues afterwards.
- S3, mode 1 sample (v2=1):
  - If cnt==0, latch len <= max(acc_len,1).
  - total = acc + prod, saturated to the ACC_W range: unsigned [0, 2^ACC_W-1], signed [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation sets ovf.
  - If cnt==len-1: y <= total, out_valid <= 1, acc <= 0, cnt <= 0.
  - Otherwise: acc <= total, cnt <= cnt+1, out_valid <= 0.
- S3 with v2=0: out_valid <= 0; y holds its last value.
- Latency: a sample accepted on ce edge k produces out_valid on ce edge k+2 (3rd enabled edge counting the capture edge). Throughput is one sample per enabled cycle.
- ce=0: all registers hold. out_valid holds its value but is qualified by ce: consumers sample only when ce=1, and the same result is not reported twice.
- clr=1:
  - acc <= 0, cnt <= 0, ovf <= 0.
  - A mode-1 sample in S3 on the same edge is dropped and produces no output.
  - A mode-0 sample in S3 is output normally.
  - The pipeline stages S1/S2 are unaffected.
- acc_len changes mid-batch are ignored until the next batch start. acc_len=0 is treated as 1.
- ovf stays 1 until rst_n or clr.

Test Plan:
1. Unsigned mode 0: a=3, b=4, c=5, in_valid=1 with ce=1 held. Required: sum_res=7 after edge 1; out_valid=1 with y=35 after edge 3 only.
2. Stall: same stimulus with ce=0 for 2 cycles after capture. Required: out_valid appears exactly 2 cycles later, y=35, no duplicate pulse.
3. Accumulate: mode=1, acc_len=4, inputs (1,1,2),(2,2,3),(0,1,1),(5,5,1) back-to-back. Products are 4, 12, 1, 10. Required: a single out_valid with y=27 on the 4th result slot, none before; then cnt=0.
4. Saturation: SIGNED=0, mode=1, acc_len=255, a=b=c=255 every cycle. Product is 130050 per sample. Required: y=16777215, ovf=1 and held; clr then gives ovf=0.
5. Signed: SIGNED=1, mode 0, a=-3, b=-4, c=5. Required: y=24'hFFFFDD (-35). Also a=-128, b=-128, c=-128 gives y=32768.
6. Interruptions:
   - rst_n low after 2 of 4 batch samples: all outputs 0 immediately. A fresh 4-sample batch then yields only its own sum.
   - A mode-0 sample interleaved mid-batch: yields its own product, and the batch total is unchanged.
